// File: rtl/mem_port_arbiter.sv
// Arbitrates I-fetch and LSU onto one sync memory port; grant is combinational, read data returns 1 cycle later.
// Backpressure: a losing requester sees ready=0 and must hold its request; D wins unless I has waited STARVE_LIMIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       grant_i;
  logic       grant_d;
  logic       force_i;
  logic       rd_grant;
  logic       rd_pending;
  logic       rd_owner;
  logic [3:0] starve_cnt;

  assign force_i = (starve_cnt == LIMIT);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (force_i && i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_ready   = grant_i;
  assign d_ready   = grant_d;
  assign mem_en    = grant_i | grant_d;
  assign mem_we    = grant_d & d_we;
  assign mem_addr  = grant_i ? i_addr : (grant_d ? d_addr : '0);
  assign mem_wdata = grant_d ? d_wdata : '0;

  // Owner 1 means the outstanding read belongs to the LSU.
  assign rd_grant = grant_i | (grant_d & ~d_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      rd_pending <= rd_grant;
      rd_owner   <= grant_d;
      if (i_req && !grant_i) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  // Return path is not gated by reset so a read accepted just before reset still completes.
  assign i_rvalid = rd_pending & ~rd_owner;
  assign d_rvalid = rd_pending & rd_owner;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for mem_port_arbiter, checked against a cycle-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ready, i_rvalid, d_ready, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Physical synchronous RAM driven by the DUT's memory command.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model state: what memory should hold, how long I has waited, what read is due back.
  logic [DW-1:0] mm [256];
  int            waited;
  bit            exp_pend, exp_owner_d;
  logic [DW-1:0] exp_data;
  bit            gi, gd;
  int            vectors, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    logic [AW-1:0] ea;
    @(negedge clk);
    gi = 0;
    gd = 0;
    if (!reset) begin
      if (i_req && waited >= SL) gi = 1;
      else if (d_req)            gd = 1;
      else if (i_req)            gi = 1;
    end
    ea = gi ? i_addr : (gd ? d_addr : '0);
    chk("i_ready",   32'(i_ready),   32'(gi));
    chk("d_ready",   32'(d_ready),   32'(gd));
    chk("mem_en",    32'(mem_en),    32'(gi | gd));
    chk("mem_we",    32'(mem_we),    32'(gd & d_we));
    chk("mem_addr",  32'(mem_addr),  32'(ea));
    chk("mem_wdata", 32'(mem_wdata), gd ? 32'(d_wdata) : 32'd0);
    chk("i_rvalid",  32'(i_rvalid),  32'(exp_pend & !exp_owner_d));
    chk("d_rvalid",  32'(d_rvalid),  32'(exp_pend & exp_owner_d));
    chk("i_rdata",   32'(i_rdata),   (exp_pend && !exp_owner_d) ? 32'(exp_data) : 32'd0);
    chk("d_rdata",   32'(d_rdata),   (exp_pend && exp_owner_d)  ? 32'(exp_data) : 32'd0);
    if (reset)             waited = 0;
    else if (i_req && !gi) waited = (waited < SL) ? waited + 1 : SL;
    else                   waited = 0;
    exp_pend    = gi || (gd && !d_we);
    exp_owner_d = gd;
    exp_data    = gi ? mm[i_addr] : mm[d_addr];
    if (gd && d_we) mm[d_addr] = d_wdata;
    @(posedge clk);
    #1;
  endtask

  // Requesters hold an unaccepted request; otherwise draw a fresh one.
  task automatic rnd_drive();
    if (!(i_req && !gi)) begin
      i_req  = ($urandom_range(0, 2) != 0);
      i_addr = AW'($urandom_range(0, 15));
    end
    if (!(d_req && !gd)) begin
      d_req   = ($urandom_range(0, 1) != 0);
      d_we    = ($urandom_range(0, 2) == 0);
      d_addr  = AW'($urandom_range(0, 15));
      d_wdata = DW'($urandom);
    end
    reset = ($urandom_range(0, 60) == 0);
  endtask

  initial begin
    vectors = 0; errors = 0; waited = 0;
    exp_pend = 0; exp_owner_d = 0; exp_data = '0; gi = 0; gd = 0;
    for (int k = 0; k < 256; k++) begin
      ram[k] = DW'($urandom);
      mm[k]  = ram[k];
    end
    ram[8'h10] = 16'hBEEF;  mm[8'h10] = 16'hBEEF;
    mem_rdata = '0;
    reset = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    // Reset holds with requests present: nothing may be granted.
    step();
    i_req = 1; d_req = 1;
    step();
    i_req = 0; d_req = 0; reset = 0;
    repeat (10) step();

    // I-only read of 0x10.
    i_req = 1; i_addr = 8'h10;
    step();
    i_req = 0;
    step();

    // D write then read back of 0x20.
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 16'h1234;
    step();
    d_we = 0;
    step();
    d_req = 0;
    step();

    // Simultaneous D read 0x05 and I read 0x06.
    d_req = 1; d_addr = 8'h05; i_req = 1; i_addr = 8'h06;
    step();
    d_req = 0;
    step();
    i_req = 0;
    step();

    // Starvation: both held for several periods of the guard.
    d_req = 1; d_we = 0; d_addr = 8'h07; i_req = 1; i_addr = 8'h08;
    repeat (15) step();
    d_req = 0; i_req = 0;
    step();

    // Reset lands right after an I read is accepted.
    i_req = 1; i_addr = 8'h30;
    step();
    i_req = 0; reset = 1; d_req = 1; d_we = 0;
    step();
    step();
    reset = 0; d_req = 0;
    step();

    for (int n = 0; n < 3000; n++) begin
      rnd_drive();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
